// File: rtl/im_stream_reader.sv
// ---------------------------------------------------------------------------
// im_stream_reader
//
// Read master for imemory. A command (bank, base address, length) is turned
// into a run of imemory reads (isel/r_en/r_addr). The returned words
// (r_data, one cycle after r_en) are buffered in a 2-entry FIFO and leave as
// a valid/ready stream with a last flag on the final word.
//
// Stream handshake: a word moves on every rising clk edge where
// o_valid=1 and o_ready=1. o_valid never depends on o_ready. While o_valid=1
// and o_ready=0, o_data and o_last hold their values.
//
// Optional feature: define IM_RD_CSUM_EN to add the csum output, a running
// modulo-2**IM_DATA_W sum of every accepted stream word of the current
// transfer. It is cleared when a start is accepted.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            command strobe, only looked at while busy=0
//   cmd_isel         bank to read (0..2 ROM0..2, 3 RAM)
//   cmd_addr         first address
//   cmd_len          word count 0..2**IM_ADDR_W
//   abort            cancel the current transfer (wins over start)
//   busy             transfer in progress
//   done             one-cycle pulse on normal completion
//   isel/r_en/r_addr read port toward imemory
//   r_data           read data from imemory (1-cycle latency)
//   o_valid/o_ready  stream handshake
//   o_data/o_last    stream word and end-of-transfer flag
//   csum             running sum of accepted words (IM_RD_CSUM_EN only)
// ---------------------------------------------------------------------------
module im_stream_reader #(
   parameter int IM_DATA_W = 12,
   parameter int IM_ADDR_W = 4,
   parameter int IM_ISEL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [IM_ISEL_W-1:0] cmd_isel,
   input  logic [IM_ADDR_W-1:0] cmd_addr,
   input  logic [IM_ADDR_W:0]   cmd_len,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [IM_ISEL_W-1:0] isel,
   output logic                 r_en,
   output logic [IM_ADDR_W-1:0] r_addr,
   input  logic [IM_DATA_W-1:0] r_data,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [IM_DATA_W-1:0] o_data,
`ifdef IM_RD_CSUM_EN
   output logic                 o_last,
   output logic [IM_DATA_W-1:0] csum
`else
   output logic                 o_last
`endif
);

   // FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [IM_ADDR_W:0] LEN_ONE = {{IM_ADDR_W{1'b0}}, 1'b1};

   logic [1:0]           state;
   logic [IM_ADDR_W:0]   len_q;
   logic [IM_ADDR_W:0]   issued;
   logic                 inflight;       // r_en of the previous cycle
   logic                 inflight_last;  // that read was the final word

   logic [IM_DATA_W-1:0] fifo_data [2];
   logic [1:0]           fifo_last;
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           fifo_count;

   logic                 start_acc;
   logic                 pop;
   logic                 last_beat;
   logic                 issue_last;
   logic                 fifo_wr;
   logic [2:0]           occupancy;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   always_comb begin
      start_acc  = 1'b0;
      pop        = 1'b0;
      last_beat  = 1'b0;
      issue_last = 1'b0;
      fifo_wr    = 1'b0;
      occupancy  = 3'd0;
      r_en       = 1'b0;

      start_acc  = (state == ST_IDLE) && start && !abort;
      pop        = o_valid && o_ready;
      last_beat  = pop && o_last;
      issue_last = (issued == (len_q - LEN_ONE));
      fifo_wr    = inflight && !abort;

      // Words the FIFO will hold after this edge's pop, plus the read already
      // in flight. Counting this cycle's pop is what lets a continuously
      // ready consumer see one word per cycle while never overrunning the
      // two FIFO entries.
      occupancy  = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight};

      r_en       = (state == ST_RUN) && !abort && (issued < len_q) &&
                   (occupancy < 3'd2);
   end

   assign busy    = (state != ST_IDLE);
   assign o_valid = (fifo_count != 2'd0);
   assign o_data  = fifo_data[rd_ptr];
   assign o_last  = fifo_last[rd_ptr];

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (abort) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && (cmd_len != '0)) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (last_beat) begin
                  state <= ST_IDLE;
               end else if (r_en && issue_last) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (last_beat) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Command registers and read issue
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q  <= '0;
         issued <= '0;
         r_addr <= '0;
         isel   <= '0;
      end else if (start_acc && (cmd_len != '0)) begin
         len_q  <= cmd_len;
         issued <= '0;
         r_addr <= cmd_addr;
         isel   <= cmd_isel;
      end else if (r_en) begin
         issued <= issued + LEN_ONE;
         // Address wraps naturally at the top of the bank.
         r_addr <= r_addr + {{(IM_ADDR_W-1){1'b0}}, 1'b1};
      end
   end

   // In-flight tracking; abort drops the pending read so its data is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else if (abort) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= r_en;
         inflight_last <= r_en && issue_last;
      end
   end

   // ------------------------------------------------------------------------
   // 2-entry FIFO; the last flag travels with its word.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last    <= 2'b00;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_count   <= 2'd0;
      end else if (abort) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (fifo_wr) begin
            fifo_data[wr_ptr] <= r_data;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_count <= fifo_count + {1'b0, fifo_wr} - {1'b0, pop};
      end
   end

   // ------------------------------------------------------------------------
   // Completion pulse: zero-length command or acceptance of the last word.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
      end else begin
         done <= !abort && ((start_acc && (cmd_len == '0)) || last_beat);
      end
   end

`ifdef IM_RD_CSUM_EN
   // Running sum of accepted words; abort leaves the current value alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (start_acc) begin
         csum <= '0;
      end else if (pop && !abort) begin
         csum <= csum + o_data;
      end
   end
`endif

endmodule

// File: tb/tb_im_stream_reader.sv
// ---------------------------------------------------------------------------
// Testbench for im_stream_reader. Contains a behavioural imemory (4 banks x
// 16 words, 1-cycle read latency), a scoreboard queue of expected
// {last, data} beats filled when commands are driven, and a negedge monitor
// that pops and compares every accepted beat.
// ---------------------------------------------------------------------------
module tb_im_stream_reader;

   localparam int DW = 12;
   localparam int AW = 4;
   localparam int SW = 2;
   localparam logic [3:0] RDY_PAT = 4'b1001;  // o_ready per phase: 1,0,0,1

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [SW-1:0] cmd_isel = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW:0]   cmd_len = '0;
   logic          abort = 1'b0;
   logic          busy;
   logic          done;
   logic [SW-1:0] isel;
   logic          r_en;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data = '0;
   logic          o_valid;
   logic          o_ready;
   logic [DW-1:0] o_data;
   logic          o_last;
`ifdef IM_RD_CSUM_EN
   logic [DW-1:0] csum;
`endif

   int            n_checks = 0;
   int            n_fail = 0;
   logic [DW:0]   exp_q[$];
   logic [DW-1:0] mem [4][16];
   int            n_iss = 0;
   int            n_acc = 0;
   int            acc_total = 0;
   logic [1:0]    rdy_mode = 2'd0;  // 0 always ready, 1 pattern, 2 never
   logic [1:0]    phase = 2'd0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   always @(posedge clk) phase <= phase + 2'd1;

   assign o_ready = (rdy_mode == 2'd0) ? 1'b1 :
                    (rdy_mode == 2'd1) ? RDY_PAT[phase] : 1'b0;

   // ---------------- imemory model ----------------
   always @(posedge clk) begin
      if (r_en) r_data <= mem[isel][r_addr];
   end

   im_stream_reader #(
      .IM_DATA_W(DW),
      .IM_ADDR_W(AW),
      .IM_ISEL_W(SW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .cmd_isel (cmd_isel),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .isel     (isel),
      .r_en     (r_en),
      .r_addr   (r_addr),
      .r_data   (r_data),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_data   (o_data),
`ifdef IM_RD_CSUM_EN
      .o_last   (o_last),
      .csum     (csum)
`else
      .o_last   (o_last)
`endif
   );

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [DW:0] e;
      if (!rst_n) begin
         n_iss = 0;
         n_acc = 0;
         prev_stall = 1'b0;
      end else begin
         if (busy) check_eq("outstanding<=2", 32'(n_iss - n_acc <= 2), 32'd1);
         if (prev_stall) begin
            check_eq("stall o_valid", 32'(o_valid), 32'd1);
            check_eq("stall o_data", 32'(o_data), 32'(prev_data));
            check_eq("stall o_last", 32'(o_last), 32'(prev_last));
         end
         if (abort) begin
            exp_q.delete();
            n_iss = 0;
            n_acc = 0;
            prev_stall = 1'b0;
         end else begin
            if (r_en) n_iss++;
            if (o_valid && o_ready) begin
               n_acc++;
               acc_total++;
               check_eq("beat expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check_eq("o_data", 32'(o_data), 32'(e[DW-1:0]));
                  check_eq("o_last", 32'(o_last), 32'(e[DW]));
               end
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
            prev_last  = o_last;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                           input logic [AW:0] len, input bit accepted);
      logic [AW-1:0] a;
      start    = 1'b1;
      cmd_isel = sel;
      cmd_addr = addr;
      cmd_len  = len;
      if (accepted) begin
         for (int i = 0; i < int'(len); i++) begin
            a = addr + AW'(i);
            exp_q.push_back({(i == int'(len) - 1), mem[sel][a]});
         end
      end
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (done) begin
            cycles = i;
            break;
         end
      end
      check_eq("done seen", 32'(done), 32'd1);
      check_eq("queue drained at done", 32'(exp_q.size()), 32'd0);
      check_eq("busy low at done", 32'(busy), 32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      int base;

      for (int i = 0; i < 16; i++) begin
         mem[0][i] = 12'hE12;
         mem[1][i] = 12'h777;
         mem[2][i] = 12'h0AE;
         mem[3][i] = 12'(i + 32);
      end

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst busy", 32'(busy), 32'd0);
      check_eq("rst done", 32'(done), 32'd0);
      check_eq("rst isel", 32'(isel), 32'd0);
      check_eq("rst r_en", 32'(r_en), 32'd0);
      check_eq("rst r_addr", 32'(r_addr), 32'd0);
      check_eq("rst o_valid", 32'(o_valid), 32'd0);
      check_eq("rst o_data", 32'(o_data), 32'd0);
      check_eq("rst o_last", 32'(o_last), 32'd0);
`ifdef IM_RD_CSUM_EN
      check_eq("rst csum", 32'(csum), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // ROM0 full bank, always ready: latency and throughput
      do_start(2'd0, 4'd0, 5'd16, 1'b1);
      check_eq("t1 r_en after start", 32'(r_en), 32'd1);
      check_eq("t1 busy after start", 32'(busy), 32'd1);
      check_eq("t1 o_valid +1", 32'(o_valid), 32'd0);
      check_eq("t1 isel", 32'(isel), 32'd0);
      tick();
      check_eq("t1 o_valid +2 edge-1", 32'(o_valid), 32'd0);
      tick();
      check_eq("t1 o_valid +2", 32'(o_valid), 32'd1);
      wait_done(cyc);
      check_eq("t1 done timing", 32'(cyc), 32'd16);
`ifdef IM_RD_CSUM_EN
      check_eq("t1 csum", 32'(csum), 32'h120);
`endif
      tick();
      check_eq("t1 done one cycle", 32'(done), 32'd0);

      // RAM with address wrap
      do_start(2'd3, 4'd14, 5'd4, 1'b1);
      check_eq("t2 isel", 32'(isel), 32'd3);
      wait_done(cyc);
`ifdef IM_RD_CSUM_EN
      check_eq("t2 csum", 32'(csum), 32'h09E);
`endif
      tick();

      // RAM full bank with toggling ready; a start while busy is ignored
      rdy_mode = 2'd1;
      do_start(2'd3, 4'd0, 5'd16, 1'b1);
      repeat (3) tick();
      do_start(2'd0, 4'd2, 5'd5, 1'b0);
      wait_done(cyc);
      rdy_mode = 2'd0;
      tick();

      // zero-length command
      do_start(2'd1, 4'd3, 5'd0, 1'b1);
      check_eq("t4 done", 32'(done), 32'd1);
      check_eq("t4 r_en", 32'(r_en), 32'd0);
      check_eq("t4 busy", 32'(busy), 32'd0);
      check_eq("t4 o_valid", 32'(o_valid), 32'd0);
`ifdef IM_RD_CSUM_EN
      check_eq("t4 csum cleared", 32'(csum), 32'd0);
`endif
      tick();
      check_eq("t4 done one cycle", 32'(done), 32'd0);
      check_eq("t4 r_en later", 32'(r_en), 32'd0);
      check_eq("t4 o_valid later", 32'(o_valid), 32'd0);

      // abort after five accepted beats of ROM1
      base = acc_total;
      do_start(2'd1, 4'd0, 5'd16, 1'b1);
      for (int i = 0; i < 100; i++) begin
         if (acc_total - base >= 5) break;
         tick();
      end
      check_eq("t5 beats before abort", 32'(acc_total - base), 32'd5);
      rdy_mode = 2'd2;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("t5 o_valid after abort", 32'(o_valid), 32'd0);
      check_eq("t5 busy after abort", 32'(busy), 32'd0);
      check_eq("t5 r_en after abort", 32'(r_en), 32'd0);
      check_eq("t5 no done on abort", 32'(done), 32'd0);
`ifdef IM_RD_CSUM_EN
      check_eq("t5 csum kept", 32'(csum), 32'h553);
`endif
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("t5 quiet after abort", 32'({done, o_valid, busy}), 32'd0);
      end
      rdy_mode = 2'd0;
      do_start(2'd2, 4'd0, 5'd2, 1'b1);
      wait_done(cyc);
      tick();

      // asynchronous reset in the middle of a transfer
      do_start(2'd3, 4'd5, 5'd16, 1'b1);
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6 busy in reset", 32'(busy), 32'd0);
      check_eq("t6 done in reset", 32'(done), 32'd0);
      check_eq("t6 isel in reset", 32'(isel), 32'd0);
      check_eq("t6 r_en in reset", 32'(r_en), 32'd0);
      check_eq("t6 r_addr in reset", 32'(r_addr), 32'd0);
      check_eq("t6 o_valid in reset", 32'(o_valid), 32'd0);
      check_eq("t6 o_data in reset", 32'(o_data), 32'd0);
      check_eq("t6 o_last in reset", 32'(o_last), 32'd0);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("t6 no done after reset", 32'(done), 32'd0);
      do_start(2'd3, 4'd0, 5'd3, 1'b1);
      wait_done(cyc);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
